// File: rtl/spike_sched.sv
// spike_sched: input-side controller for the neuron core.
// It queues external weighted spikes and arbitrates the core's single
// accumulate port between periodic leak, the recurrent self-spike and queued
// external spikes. It detects threshold crossings, emits the output spike
// and holds off new operations for a refractory period after each fire.
//
// Core handshake: a request is presented with o_op_valid=1. o_op and o_op_w
// stay stable until a cycle in which i_op_ready=1, and that cycle is the
// transfer. After an accumulate or leak is accepted, the controller waits for
// the single-cycle i_op_done pulse, with i_core_ge valid in that cycle. The
// reset-V op issued on a fire completes on acceptance and is not followed by
// a done.
module spike_sched #(
    parameter int         FIFO_DEPTH  = 4,
    parameter int         LEAK_PERIOD = 16,
    parameter int         REFRAC_CYC  = 2,
    parameter logic [2:0] REC_W       = 3'd4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] i_wspike,
    input  logic       i_svalid,
    input  logic       i_recc,
    input  logic [5:0] i_Thres,
    input  logic       i_Thres_valid,
    output logic       o_op_valid,
    output logic [1:0] o_op,
    output logic [2:0] o_op_w,
    input  logic       i_op_ready,
    input  logic       i_op_done,
    input  logic       i_core_ge,
    output logic [5:0] o_thres,
    output logic       o_spike,
    output logic       o_full,
    output logic       o_drop,
    output logic [2:0] o_state
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam int LW = (LEAK_PERIOD > 1) ? $clog2(LEAK_PERIOD) : 1;
    localparam int RW = (REFRAC_CYC > 1) ? $clog2(REFRAC_CYC) : 1;

    localparam logic [CW-1:0] DEPTH_C     = CW'(FIFO_DEPTH);
    localparam logic [LW-1:0] LEAK_LAST   = LW'(LEAK_PERIOD - 1);
    localparam logic [RW-1:0] REFRAC_LAST = RW'(REFRAC_CYC - 1);

    localparam logic [1:0] OP_ACC  = 2'b00;
    localparam logic [1:0] OP_LEAK = 2'b01;
    localparam logic [1:0] OP_RSTV = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ISSUE  = 3'd1,
        ST_WAIT   = 3'd2,
        ST_FIRE   = 3'd3,
        ST_REFRAC = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        SRC_LEAK = 2'd0,
        SRC_REC  = 2'd1,
        SRC_FIFO = 2'd2
    } src_t;

    // FSM and latched request
    state_t         state_q, state_d;
    src_t           src_q, src_d;
    logic [1:0]     op_q, op_d;
    logic [2:0]     w_q, w_d;
    logic [RW-1:0]  refrac_q, refrac_d;

    // FIFO
    logic [2:0]     mem_q [FIFO_DEPTH];
    logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]  count_q, count_d;
    logic           full_q, full_d;
    logic           push, pop;

    // Pending requesters
    logic [LW-1:0]  leak_cnt_q, leak_cnt_d;
    logic           leak_wrap;
    logic           leak_pend_q, leak_pend_d;
    logic           rec_pend_q, rec_pend_d;

    // Threshold
    logic [5:0]     shadow_q, shadow_d;
    logic [5:0]     thres_q, thres_d;

    // Handshake events decoded by the FSM
    logic           accept;
    logic           fire_ack;

    // Next-state logic, request selection and core-facing outputs
    always_comb begin
        state_d    = state_q;
        src_d      = src_q;
        op_d       = op_q;
        w_d        = w_q;
        refrac_d   = refrac_q;
        accept     = 1'b0;
        fire_ack   = 1'b0;
        o_op_valid = 1'b0;
        o_op       = OP_ACC;
        o_op_w     = 3'd0;
        o_spike    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // Fixed priority: leak, then recurrent, then external queue.
                if (leak_pend_q) begin
                    src_d   = SRC_LEAK;
                    op_d    = OP_LEAK;
                    w_d     = 3'd0;
                    state_d = ST_ISSUE;
                end else if (rec_pend_q) begin
                    src_d   = SRC_REC;
                    op_d    = OP_ACC;
                    w_d     = REC_W;
                    state_d = ST_ISSUE;
                end else if (count_q != '0) begin
                    src_d   = SRC_FIFO;
                    op_d    = OP_ACC;
                    w_d     = mem_q[rd_ptr_q];
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                o_op_valid = 1'b1;
                o_op       = op_q;
                o_op_w     = w_q;
                if (i_op_ready) begin
                    accept  = 1'b1;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (i_op_done) begin
                    // A leak can lower V but never fires the neuron.
                    if (op_q == OP_ACC && i_core_ge) begin
                        state_d = ST_FIRE;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_FIRE: begin
                o_op_valid = 1'b1;
                o_op       = OP_RSTV;
                if (i_op_ready) begin
                    o_spike  = 1'b1;
                    fire_ack = 1'b1;
                    refrac_d = '0;
                    state_d  = ST_REFRAC;
                end
            end
            ST_REFRAC: begin
                if (refrac_q == REFRAC_LAST) begin
                    state_d = ST_IDLE;
                end else begin
                    refrac_d = refrac_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // FIFO, leak timer, pend bits and threshold next-state
    always_comb begin
        // A push is judged against the count at the start of the cycle, so a
        // full queue drops the spike even when a pop happens alongside.
        push     = i_svalid && !full_q;
        pop      = accept && (src_q == SRC_FIFO);
        o_drop   = i_svalid && full_q;
        wr_ptr_d = wr_ptr_q + AW'(push);
        rd_ptr_d = rd_ptr_q + AW'(pop);
        count_d  = count_q + CW'(push) - CW'(pop);
        full_d   = (count_d == DEPTH_C);

        leak_wrap  = (leak_cnt_q == LEAK_LAST);
        leak_cnt_d = leak_wrap ? '0 : leak_cnt_q + 1'b1;

        // A new wrap wins over the clear so a period is never lost.
        leak_pend_d = leak_pend_q;
        if (leak_wrap) begin
            leak_pend_d = 1'b1;
        end else if (accept && src_q == SRC_LEAK) begin
            leak_pend_d = 1'b0;
        end

        rec_pend_d = rec_pend_q;
        if (fire_ack && i_recc) begin
            rec_pend_d = 1'b1;
        end else if (accept && src_q == SRC_REC) begin
            rec_pend_d = 1'b0;
        end

        // The active threshold only moves while idle, so it is never changed
        // under an operation in flight. A write in an idle cycle bypasses the
        // shadow and is visible on the next cycle.
        shadow_d = i_Thres_valid ? i_Thres : shadow_q;
        thres_d  = (state_q == ST_IDLE) ? shadow_d : thres_q;
    end

    // Control and status registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            src_q       <= SRC_LEAK;
            op_q        <= OP_ACC;
            w_q         <= 3'd0;
            refrac_q    <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            full_q      <= 1'b0;
            leak_cnt_q  <= '0;
            leak_pend_q <= 1'b0;
            rec_pend_q  <= 1'b0;
            shadow_q    <= 6'd63;
            thres_q     <= 6'd63;
        end else begin
            state_q     <= state_d;
            src_q       <= src_d;
            op_q        <= op_d;
            w_q         <= w_d;
            refrac_q    <= refrac_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            full_q      <= full_d;
            leak_cnt_q  <= leak_cnt_d;
            leak_pend_q <= leak_pend_d;
            rec_pend_q  <= rec_pend_d;
            shadow_q    <= shadow_d;
            thres_q     <= thres_d;
        end
    end

    // FIFO storage: write the incoming weight at the tail on a push
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= 3'd0;
            end
        end else if (push) begin
            mem_q[wr_ptr_q] <= i_wspike;
        end
    end

    assign o_thres = thres_q;
    assign o_full  = full_q;
    assign o_state = state_q;

endmodule

// File: tb/tb_spike_sched.sv
// Self-checking bench for spike_sched. The bench plays the core: it drives
// i_op_ready, i_op_done and i_core_ge, and it keeps the expected issue order
// ({op, weight}) in a queue.
module tb_spike_sched;

    logic       clk;
    logic       rst;
    logic [2:0] i_wspike;
    logic       i_svalid;
    logic       i_recc;
    logic [5:0] i_Thres;
    logic       i_Thres_valid;
    logic       o_op_valid;
    logic [1:0] o_op;
    logic [2:0] o_op_w;
    logic       i_op_ready;
    logic       i_op_done;
    logic       i_core_ge;
    logic [5:0] o_thres;
    logic       o_spike;
    logic       o_full;
    logic       o_drop;
    logic [2:0] o_state;

    int         n_checks;
    int         n_fail;
    int         spike_cnt;
    logic [4:0] exp_q[$];

    spike_sched dut (
        .clk           (clk),
        .rst           (rst),
        .i_wspike      (i_wspike),
        .i_svalid      (i_svalid),
        .i_recc        (i_recc),
        .i_Thres       (i_Thres),
        .i_Thres_valid (i_Thres_valid),
        .o_op_valid    (o_op_valid),
        .o_op          (o_op),
        .o_op_w        (o_op_w),
        .i_op_ready    (i_op_ready),
        .i_op_done     (i_op_done),
        .i_core_ge     (i_core_ge),
        .o_thres       (o_thres),
        .o_spike       (o_spike),
        .o_full        (o_full),
        .o_drop        (o_drop),
        .o_state       (o_state)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Spike pulse counter
    always @(negedge clk) begin
        if (!rst && o_spike) spike_cnt++;
    end

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    // Move to just after the next rising edge, where inputs are driven.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Reset; returns in cycle 0, the first cycle with rst low.
    task automatic do_reset();
        rst           = 1'b1;
        i_wspike      = 3'd0;
        i_svalid      = 1'b0;
        i_recc        = 1'b0;
        i_Thres       = 6'd0;
        i_Thres_valid = 1'b0;
        i_op_ready    = 1'b0;
        i_op_done     = 1'b0;
        i_core_ge     = 1'b0;
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Core model: accept the next request and return done one cycle later.
    // Returns in the cycle after the done pulse.
    task automatic serve_op(input logic ge, output logic [1:0] op,
                            output logic [2:0] w, output bit ok);
        ok = 1'b0;
        op = 2'd0;
        w  = 3'd0;
        i_op_ready = 1'b1;
        for (int n = 0; n < 40 && !ok; n++) begin
            @(negedge clk);
            if (o_op_valid && o_state == 3'd1) begin
                op = o_op;
                w  = o_op_w;
                ok = 1'b1;
            end
            next_cycle();
        end
        if (ok) begin
            i_op_done = 1'b1;
            i_core_ge = ge;
            next_cycle();
            i_op_done = 1'b0;
            i_core_ge = 1'b0;
        end
    endtask

    task automatic test_reset();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            i_svalid = 1'b1;
            i_wspike = 3'(i + 1);
            next_cycle();
        end
        i_svalid      = 1'b0;
        i_Thres       = 6'd30;
        i_Thres_valid = 1'b1;
        next_cycle();
        i_Thres_valid = 1'b0;
        repeat (12) next_cycle();
        // Cycle 17: queue full, request stalled, leak pending.
        @(negedge clk);
        n_checks++; if (o_full !== 1'b1) begin n_fail++; $display("FAIL reset_pre_full: got %0b expected 1", o_full); end
        n_checks++; if (o_op_valid !== 1'b1) begin n_fail++; $display("FAIL reset_pre_valid: got %0b expected 1", o_op_valid); end
        #1 rst = 1'b1;
        #1;
        n_checks++; if (o_state !== 3'd0) begin n_fail++; $display("FAIL reset_state: got %0d expected 0", o_state); end
        n_checks++; if (o_op_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %0b expected 0", o_op_valid); end
        n_checks++; if (o_op !== 2'b00) begin n_fail++; $display("FAIL reset_op: got %0b expected 00", o_op); end
        n_checks++; if (o_op_w !== 3'd0) begin n_fail++; $display("FAIL reset_op_w: got %0d expected 0", o_op_w); end
        n_checks++; if (o_thres !== 6'd63) begin n_fail++; $display("FAIL reset_thres: got %0d expected 63", o_thres); end
        n_checks++; if (o_spike !== 1'b0) begin n_fail++; $display("FAIL reset_spike: got %0b expected 0", o_spike); end
        n_checks++; if (o_full !== 1'b0) begin n_fail++; $display("FAIL reset_full: got %0b expected 0", o_full); end
        n_checks++; if (o_drop !== 1'b0) begin n_fail++; $display("FAIL reset_drop: got %0b expected 0", o_drop); end
        next_cycle();
        @(negedge clk);
        n_checks++; if (o_state !== 3'd0) begin n_fail++; $display("FAIL reset_held_state: got %0d expected 0", o_state); end
        next_cycle();
        rst = 1'b0;
        next_cycle();
        // Cycle 1 after release: shadow threshold was lost, nothing pending.
        @(negedge clk);
        n_checks++; if (o_thres !== 6'd63) begin n_fail++; $display("FAIL reset_shadow_lost: got %0d expected 63", o_thres); end
        n_checks++; if (o_op_valid !== 1'b0) begin n_fail++; $display("FAIL reset_no_op: got %0b expected 0", o_op_valid); end
    endtask

    task automatic test_fifo_full_drop();
        int         model_cnt;
        logic [1:0] op;
        logic [2:0] w;
        logic [4:0] exp;
        bit         ok;
        do_reset();
        model_cnt = 0;
        for (int i = 0; i < 5; i++) begin
            i_svalid = 1'b1;
            i_wspike = 3'(i + 1);
            @(negedge clk);
            n_checks++; if (o_full !== (model_cnt == 4)) begin n_fail++; $display("FAIL fifo_full_%0d: got %0b expected %0b", i, o_full, model_cnt == 4); end
            n_checks++; if (o_drop !== (model_cnt == 4)) begin n_fail++; $display("FAIL fifo_drop_%0d: got %0b expected %0b", i, o_drop, model_cnt == 4); end
            if (model_cnt < 4) begin
                exp_q.push_back({2'b00, 3'(i + 1)});
                model_cnt++;
            end
            next_cycle();
        end
        i_svalid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            serve_op(1'b0, op, w, ok);
            n_checks++; if (!ok) begin n_fail++; $display("FAIL fifo_issue_%0d_timeout: got none expected request", k); end
            exp = exp_q.pop_front();
            n_checks++; if ({op, w} !== exp) begin n_fail++; $display("FAIL fifo_issue_%0d: got op=%0b w=%0d expected op=%0b w=%0d", k, op, w, exp[4:3], exp[2:0]); end
            if (k == 0) begin
                @(negedge clk);
                n_checks++; if (o_full !== 1'b0) begin n_fail++; $display("FAIL fifo_full_after_pop: got %0b expected 0", o_full); end
                next_cycle();
            end
        end
    endtask

    task automatic test_thres_shadow();
        logic [4:0] exp;
        do_reset();
        i_op_ready = 1'b1;
        i_svalid   = 1'b1;
        i_wspike   = 3'd2;
        exp_q.push_back({2'b00, 3'd2});
        next_cycle();
        i_svalid = 1'b0;
        next_cycle();
        // Cycle 2: request on the port, accepted this cycle.
        @(negedge clk);
        exp = exp_q.pop_front();
        n_checks++; if ({o_op_valid, o_op, o_op_w} !== {1'b1, exp}) begin n_fail++; $display("FAIL thres_issue: got v=%0b op=%0b w=%0d expected v=1 op=%0b w=%0d", o_op_valid, o_op, o_op_w, exp[4:3], exp[2:0]); end
        next_cycle();
        // Cycle 3: WAIT, write new threshold.
        i_Thres       = 6'd10;
        i_Thres_valid = 1'b1;
        @(negedge clk);
        n_checks++; if (o_state !== 3'd2) begin n_fail++; $display("FAIL thres_wait_state: got %0d expected 2", o_state); end
        next_cycle();
        i_Thres_valid = 1'b0;
        i_Thres       = 6'd0;
        @(negedge clk);
        n_checks++; if (o_thres !== 6'd63) begin n_fail++; $display("FAIL thres_hold_wait: got %0d expected 63", o_thres); end
        next_cycle();
        // Cycle 5: done, no crossing.
        i_op_done = 1'b1;
        @(negedge clk);
        n_checks++; if (o_thres !== 6'd63) begin n_fail++; $display("FAIL thres_hold_done: got %0d expected 63", o_thres); end
        next_cycle();
        i_op_done = 1'b0;
        @(negedge clk);
        n_checks++; if (o_state !== 3'd0) begin n_fail++; $display("FAIL thres_back_idle: got %0d expected 0", o_state); end
        next_cycle();
        @(negedge clk);
        n_checks++; if (o_thres !== 6'd10) begin n_fail++; $display("FAIL thres_applied: got %0d expected 10", o_thres); end
        next_cycle();
        // Cycle 8: write while idle, visible next cycle.
        i_Thres       = 6'd20;
        i_Thres_valid = 1'b1;
        @(negedge clk);
        n_checks++; if (o_thres !== 6'd10) begin n_fail++; $display("FAIL thres_idle_same_cycle: got %0d expected 10", o_thres); end
        next_cycle();
        i_Thres_valid = 1'b0;
        @(negedge clk);
        n_checks++; if (o_thres !== 6'd20) begin n_fail++; $display("FAIL thres_idle_next: got %0d expected 20", o_thres); end
    endtask

    task automatic test_fire_recurrent();
        int         spikes0;
        logic [1:0] op;
        logic [2:0] w;
        logic [4:0] exp;
        bit         ok;
        logic [2:0] wts [3];
        wts[0] = 3'd3;
        wts[1] = 3'd5;
        wts[2] = 3'd6;
        do_reset();
        i_op_ready = 1'b1;
        spikes0    = spike_cnt;
        for (int i = 0; i < 3; i++) begin
            i_svalid = 1'b1;
            i_wspike = wts[i];
            exp_q.push_back({2'b00, wts[i]});
            if (i == 2) begin
                @(negedge clk);
                exp = exp_q.pop_front();
                n_checks++; if ({o_state, o_op, o_op_w} !== {3'd1, exp}) begin n_fail++; $display("FAIL fire_first_issue: got st=%0d op=%0b w=%0d expected st=1 op=%0b w=%0d", o_state, o_op, o_op_w, exp[4:3], exp[2:0]); end
            end
            next_cycle();
        end
        // Cycle 3: done with crossing, recurrent enabled.
        i_svalid  = 1'b0;
        i_op_done = 1'b1;
        i_core_ge = 1'b1;
        i_recc    = 1'b1;
        exp_q.push_front({2'b00, 3'd4});
        next_cycle();
        // Cycle 4: reset-V request and spike.
        i_op_done = 1'b0;
        i_core_ge = 1'b0;
        @(negedge clk);
        n_checks++; if ({o_state, o_op_valid, o_op, o_op_w} !== {3'd3, 1'b1, 2'b10, 3'd0}) begin n_fail++; $display("FAIL fire_req: got st=%0d v=%0b op=%0b w=%0d expected st=3 v=1 op=10 w=0", o_state, o_op_valid, o_op, o_op_w); end
        n_checks++; if (o_spike !== 1'b1) begin n_fail++; $display("FAIL fire_spike: got %0b expected 1", o_spike); end
        next_cycle();
        i_recc = 1'b0;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            n_checks++; if ({o_state, o_op_valid} !== {3'd4, 1'b0}) begin n_fail++; $display("FAIL fire_refrac_%0d: got st=%0d v=%0b expected st=4 v=0", c, o_state, o_op_valid); end
            next_cycle();
        end
        @(negedge clk);
        n_checks++; if (o_state !== 3'd0) begin n_fail++; $display("FAIL fire_refrac_end: got %0d expected 0", o_state); end
        n_checks++; if (spike_cnt - spikes0 !== 1) begin n_fail++; $display("FAIL fire_spike_count: got %0d expected 1", spike_cnt - spikes0); end
        for (int k = 0; k < 3; k++) begin
            serve_op(1'b0, op, w, ok);
            n_checks++; if (!ok) begin n_fail++; $display("FAIL fire_issue_%0d_timeout: got none expected request", k); end
            exp = exp_q.pop_front();
            n_checks++; if ({op, w} !== exp) begin n_fail++; $display("FAIL fire_issue_%0d: got op=%0b w=%0d expected op=%0b w=%0d", k, op, w, exp[4:3], exp[2:0]); end
        end
    endtask

    task automatic test_leak_priority();
        int         spikes0;
        logic [1:0] op;
        logic [2:0] w;
        logic [4:0] exp;
        bit         ok;
        do_reset();
        spikes0 = spike_cnt;
        repeat (15) next_cycle();
        // Cycle 15: push lands together with the leak wrap.
        i_svalid = 1'b1;
        i_wspike = 3'd7;
        exp_q.push_back({2'b01, 3'd0});
        exp_q.push_back({2'b00, 3'd7});
        next_cycle();
        i_svalid = 1'b0;
        @(negedge clk);
        n_checks++; if (o_state !== 3'd0) begin n_fail++; $display("FAIL leak_idle: got %0d expected 0", o_state); end
        serve_op(1'b1, op, w, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL leak_issue_timeout: got none expected request"); end
        exp = exp_q.pop_front();
        n_checks++; if ({op, w} !== exp) begin n_fail++; $display("FAIL leak_first: got op=%0b w=%0d expected op=%0b w=%0d", op, w, exp[4:3], exp[2:0]); end
        @(negedge clk);
        n_checks++; if (o_state !== 3'd0) begin n_fail++; $display("FAIL leak_no_fire_state: got %0d expected 0", o_state); end
        serve_op(1'b0, op, w, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL leak_acc_timeout: got none expected request"); end
        exp = exp_q.pop_front();
        n_checks++; if ({op, w} !== exp) begin n_fail++; $display("FAIL leak_second: got op=%0b w=%0d expected op=%0b w=%0d", op, w, exp[4:3], exp[2:0]); end
        n_checks++; if (spike_cnt - spikes0 !== 0) begin n_fail++; $display("FAIL leak_no_spike: got %0d expected 0", spike_cnt - spikes0); end
    endtask

    task automatic test_reset_abort();
        int         early;
        logic [4:0] exp;
        do_reset();
        i_op_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            i_svalid = 1'b1;
            i_wspike = 3'(i + 1);
            next_cycle();
        end
        i_svalid = 1'b0;
        next_cycle();
        // Cycle 4: WAIT with two entries queued, no done given.
        @(negedge clk);
        n_checks++; if (o_state !== 3'd2) begin n_fail++; $display("FAIL abort_pre_state: got %0d expected 2", o_state); end
        #1 rst = 1'b1;
        #1;
        n_checks++; if ({o_state, o_op_valid, o_full} !== {3'd0, 1'b0, 1'b0}) begin n_fail++; $display("FAIL abort_now: got st=%0d v=%0b full=%0b expected st=0 v=0 full=0", o_state, o_op_valid, o_full); end
        next_cycle();
        rst = 1'b0;
        exp_q.push_back({2'b01, 3'd0});
        early = 0;
        for (int c = 0; c < 17; c++) begin
            @(negedge clk);
            if (o_op_valid) early++;
            next_cycle();
        end
        n_checks++; if (early !== 0) begin n_fail++; $display("FAIL abort_quiet: got %0d requests expected 0", early); end
        // Cycle 17: the first leak.
        @(negedge clk);
        exp = exp_q.pop_front();
        n_checks++; if ({o_op_valid, o_op, o_op_w} !== {1'b1, exp}) begin n_fail++; $display("FAIL abort_first_leak: got v=%0b op=%0b w=%0d expected v=1 op=%0b w=%0d", o_op_valid, o_op, o_op_w, exp[4:3], exp[2:0]); end
        next_cycle();
        i_op_done = 1'b1;
        next_cycle();
        i_op_done = 1'b0;
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        spike_cnt = 0;
        test_reset();
        test_fifo_full_drop();
        test_thres_shadow();
        test_fire_recurrent();
        test_leak_priority();
        test_reset_abort();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
